// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the instruction-memory loader
//
// Purpose: state encoding and fixed widths shared by imem_loader and
//          imem_loader_csum.
// Contents:
//   LEN_W   width of the length word and the program-word counter
//   CSUM_W  width of the modulo-2^16 checksum
//   state_t loader FSM states

package loader_pkg;

  localparam int LEN_W  = 16;
  localparam int CSUM_W = 16;

  typedef enum logic [2:0] {
    S_LEN   = 3'd0,
    S_DATA  = 3'd1,
    S_CHK   = 3'd2,
    S_HOLD  = 3'd3,
    S_RUN   = 3'd4,
    S_ERROR = 3'd5
  } state_t;

endpackage

// File: rtl/imem_loader_csum.sv
// rtl/imem_loader_csum.sv - modulo-2^16 running sum with clear, add and compare
//
// Purpose: accumulates program words so the loader can verify the trailing
//          checksum word of the stream.
// Ports:
//   clk       in   system clock
//   reset     in   synchronous active-low reset, clears the sum
//   clr       in   clear the sum on this edge (takes priority over add_en)
//   add_en    in   add add_data into the sum on this edge
//   add_data  in   word to accumulate
//   cmp_data  in   word compared against the current sum
//   match     out  1 when cmp_data equals the current sum (combinational)

module imem_loader_csum
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              add_en,
  input  logic [CSUM_W-1:0] add_data,
  input  logic [CSUM_W-1:0] cmp_data,
  output logic              match
);

  logic [CSUM_W-1:0] sum;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (add_en) begin
      // Natural overflow of the CSUM_W-bit adder gives the modulo-2^16 sum.
      sum <= sum + add_data;
    end
  end

  assign match = (sum == cmp_data);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time instruction-memory loader with processor reset hold
//
// Purpose: accepts a length-prefixed stream of 16-bit words, writes the
//          program words to instruction memory from address 0, then releases
//          the processor reset RELEASE_DLY cycles after the last transfer.
// Build option: LOADER_CSUM_EN - when defined, a checksum word follows the
//          data and a mismatch parks the loader in ERROR.
// Parameters:
//   ADDR_W       instruction-memory word-address width (>= 16)
//   DATA_W       instruction word width (16)
//   RELEASE_DLY  cycles spent in HOLD before cpu_reset rises (>= 1)
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-low reset
//   in_valid   in   upstream word valid
//   in_data    in   upstream word
//   in_ready   out  loader accepts a word this cycle
//   mem_we     out  one-cycle write strobe per program word
//   mem_addr   out  write word address
//   mem_wdata  out  write data
//   cpu_reset  out  active-low processor reset (1 = run)
//   busy       out  loading in progress (LEN, DATA, CHK, HOLD)
//   done       out  program loaded and processor released
//   error      out  checksum mismatch, sticky until reset

module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W      = 21,
  parameter int DATA_W      = 16,
  parameter int RELEASE_DLY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int DLY_W = $clog2(RELEASE_DLY + 1);

`ifdef LOADER_CSUM_EN
  localparam state_t AFTER_DATA = S_CHK;
`else
  localparam state_t AFTER_DATA = S_HOLD;
`endif

  state_t             state;
  state_t             state_next;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt;
  logic [DLY_W-1:0]   dly_cnt;
  logic               xfer;
  logic               csum_match;

  assign xfer = in_valid & in_ready;

`ifdef LOADER_CSUM_EN
  imem_loader_csum u_csum (
    .clk      (clk),
    .reset    (reset),
    .clr      ((state == S_LEN) && xfer),
    .add_en   ((state == S_DATA) && xfer),
    .add_data (CSUM_W'(in_data)),
    .cmp_data (CSUM_W'(in_data)),
    .match    (csum_match)
  );
`else
  // CHK is unreachable without the checksum option.
  assign csum_match = 1'b1;
`endif

  always_comb begin
    state_next = state;
    case (state)
      S_LEN: begin
        if (xfer) begin
          state_next = (in_data == '0) ? AFTER_DATA : S_DATA;
        end
      end
      S_DATA: begin
        if (xfer && (cnt == len_q - LEN_W'(1))) begin
          state_next = AFTER_DATA;
        end
      end
      S_CHK: begin
        if (xfer) begin
          state_next = csum_match ? S_HOLD : S_ERROR;
        end
      end
      S_HOLD: begin
        if (dly_cnt == DLY_W'(RELEASE_DLY - 1)) begin
          state_next = S_RUN;
        end
      end
      default: begin
        state_next = state;
      end
    endcase
  end

  // Control outputs are registered from state_next so each one changes on
  // the same edge as the state it reflects.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_LEN;
      len_q     <= '0;
      cnt       <= '0;
      dly_cnt   <= '0;
      in_ready  <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_reset <= 1'b0;
      busy      <= 1'b1;
      done      <= 1'b0;
    end else begin
      state  <= state_next;
      mem_we <= 1'b0;

      if ((state == S_LEN) && xfer) begin
        len_q <= LEN_W'(in_data);
        cnt   <= '0;
      end

      if ((state == S_DATA) && xfer) begin
        mem_we    <= 1'b1;
        mem_addr  <= ADDR_W'(cnt);
        mem_wdata <= in_data;
        cnt       <= cnt + LEN_W'(1);
      end

      // Counts only while in HOLD; zero on every HOLD entry.
      dly_cnt <= (state == S_HOLD) ? dly_cnt + DLY_W'(1) : '0;

      in_ready  <= (state_next == S_LEN) || (state_next == S_DATA) ||
                   (state_next == S_CHK);
      busy      <= (state_next == S_LEN) || (state_next == S_DATA) ||
                   (state_next == S_CHK) || (state_next == S_HOLD);
      cpu_reset <= (state_next == S_RUN);
      done      <= (state_next == S_RUN);
    end
  end

`ifdef LOADER_CSUM_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      error <= 1'b0;
    end else begin
      error <= (state_next == S_ERROR);
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule
